mux_8_1_rr_sched: RTL and testbench
===================================

Name: mux_8_1_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 mux datapath among 8 requesters.
- Arbitrates the req lines and drives a stable 3-bit select into the mux.
- Presents the selected data on a valid/ready output port.
- Enforces a per-grant burst limit so that no requester monopolises the mux.

Parameters:
- DATA_W, 1: width of each requester data lane and of out_data.
- MAX_BURST, 4: maximum accepted beats per grant before forced rotation; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i is requester i.
- d_in  input  8*DATA_W  data lanes; lane i = d_in[i*DATA_W +: DATA_W].
- out_ready  input  1  downstream accepts a beat when high.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  DATA_W  lane selected by out_sel.
- out_sel  output  3  registered mux select (index of the granted requester).
- grant  output  8  one-hot grant, all-zero when idle.

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, out_sel=0, out_valid=0, ptr=0, beat_cnt=0.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
- States: IDLE, BUSY.
- IDLE, no req: stay in IDLE with grant=0.
- IDLE, any req bit set at edge n: at edge n+1 state=BUSY, out_sel=picked index, grant=one-hot(out_sel), beat_cnt=0. Arbitration latency is 1 cycle.
- BUSY: out_valid = req[out_sel], combinational from the registered select. out_data = d_in lane[out_sel], purely combinational mux.
- Beat: a beat is accepted when out_valid && out_ready at a rising edge.
- Beat accepted with beat_cnt < MAX_BURST-1: beat_cnt += 1 and the grant is held.
- Release occurs on either condition:
  - (a) a beat is accepted with beat_cnt == MAX_BURST-1;
  - (b) req[out_sel] is low at the edge (requester withdrew; no beat counted).
- On release:
  - ptr = out_sel+1 mod 8 (7 wraps to 0) and beat_cnt=0.
  - Arbitration then runs on the current req using the new ptr.
  - If any req is set: stay BUSY and load the new out_sel/grant at the same edge. This gives back-to-back grants with no idle bubble.
  - Otherwise go to IDLE with grant=0.
- A lone requester that stays asserted is re-granted immediately after its own release; beat_cnt restarts at 0.
- out_ready low: hold state, out_sel and beat_cnt; out_valid stays asserted while req[out_sel] is high.
- out_sel and grant change only at release edges; they are never updated mid-grant. out_data therefore never switches lane during a burst.
- MAX_BURST=1: every accepted beat releases and rotates.
- beat_cnt width: $clog2(MAX_BURST+1).
- Requests from non-granted requesters are ignored until release; there is no preemption.
- rst asserted mid-burst: all state clears immediately, out_valid drops asynchronously, and the in-flight beat is not counted.

Decomposition:
- Package mux_8_1_sched_pkg contains:
  - NUM_REQ=8 and SEL_W=3;
  - state enum {IDLE, BUSY};
  - function next_idx(idx) implementing the mod-8 increment.
- Sub-module rr_pick_8: combinational; inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and found.
- The data mux is implemented inline as an indexed part-select.

Test Plan:
- rst high, then req=8'h00 for 3 cycles -> grant=0, out_valid=0, out_sel=0 throughout.
- req=8'b0000_0101, out_ready=1, MAX_BURST=4, held constant -> grant=01 for 4 beats, then 04 for 4 beats, then 01 (back-to-back, no bubble); out_data tracks lane 0 then lane 2.
- out_sel=7 granted, req=8'h81, one beat accepted, then req[7] drops -> release after 1 beat; ptr wraps to 0; grant=01 next cycle.
- out_ready held low for 5 cycles mid-burst with beat_cnt=2 -> out_valid=1, out_sel and beat_cnt frozen; burst completes after 2 more accepted beats.
- MAX_BURST=1, req=8'hFF, out_ready=1 -> grant rotates 01, 02, 04, ..., 80, 01, one beat each.
- rst pulsed for 1 cycle during a burst on requester 3 -> grant=0 and out_valid=0 immediately; after rst falls with req[3] still high, grant=08 one cycle later with beat_cnt=0.

Source files
------------

// File: rtl/mux_8_1_sched_pkg.sv
`default_nettype none
// ============================================================================
// mux_8_1_sched_pkg : shared types and helpers for the 8:1 round-robin mux
// Revision: 1.0
// ============================================================================
package mux_8_1_sched_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Relies on SEL_W-bit wrap-around: 7 + 1 -> 0
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_8.sv
`default_nettype none
// ============================================================================
// rr_pick_8 : combinational round-robin picker, ptr has highest priority
// Revision: 1.0
// ============================================================================
module rr_pick_8
    import mux_8_1_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] w_cand;

    assign found = |req;

    // Walk from the farthest offset back to ptr so the closest hit wins
    always_comb begin
        idx    = ptr;
        w_cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = ptr + SEL_W'(i);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_8_1_rr_sched.sv
`default_nettype none
// ============================================================================
// mux_8_1_rr_sched : 8-requester round-robin scheduler driving an 8:1 mux
// Revision: 1.0
// ============================================================================
module mux_8_1_rr_sched
    import mux_8_1_sched_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] d_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic [NUM_REQ-1:0]        grant
);

    localparam int               CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] w_pick_ptr;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_accept;
    logic             w_release;

    // While busy, arbitration only matters on release, where ptr becomes sel+1
    assign w_pick_ptr = (state_q == BUSY) ? next_idx(sel_q) : ptr_q;

    rr_pick_8 u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign out_valid = (state_q == BUSY) && req[sel_q];
    assign out_data  = d_in[sel_q*DATA_W +: DATA_W];
    assign out_sel   = sel_q;
    assign grant     = (state_q == BUSY) ? (NUM_REQ'(1) << sel_q) : '0;

    assign w_accept  = out_valid && out_ready;
    assign w_release = (state_q == BUSY) &&
                       (!req[sel_q] || (w_accept && (cnt_q == c_LAST)));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_pick_found) begin
                    state_d = BUSY;
                    sel_d   = w_pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    ptr_d = next_idx(sel_q);
                    cnt_d = '0;
                    if (w_pick_found) begin
                        sel_d = w_pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_8_1_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_mux_8_1_rr_sched : bench for two scheduler instances (MAX_BURST 4 and 1)
// Revision: 1.0
// ============================================================================
module tb_mux_8_1_rr_sched;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    req = '0;
    logic [8*DW-1:0] d_in = '0;
    logic          out_ready = 1'b0;

    logic          ov0, ov1;
    logic [DW-1:0] od0, od1;
    logic [2:0]    os0, os1;
    logic [7:0]    g0, g1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 -> MAX_BURST=4, index 1 -> MAX_BURST=1
    int mb[2] = '{4, 1};
    bit m_busy[2];
    int m_sel[2];
    int m_ptr[2];
    int m_beats[2];

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] g4;
        logic [7:0] g1;
        logic       v;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    mux_8_1_rr_sched #(.DATA_W(DW), .MAX_BURST(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in), .out_ready(out_ready),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .grant(g0)
    );

    mux_8_1_rr_sched #(.DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in), .out_ready(out_ready),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .grant(g1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]  = 1'b0;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_beats[i] = 0;
        end
    endtask

    // One rising edge in terms of grants and beats-per-grant
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rel;
            rel = 1'b0;
            if (!m_busy[i]) begin
                if (req != 0) begin
                    m_busy[i]  = 1'b1;
                    m_sel[i]   = search(req, m_ptr[i]);
                    m_beats[i] = 0;
                end
            end else begin
                if (!req[m_sel[i]]) begin
                    rel = 1'b1;
                end else if (out_ready) begin
                    m_beats[i]++;
                    if (m_beats[i] == mb[i]) rel = 1'b1;
                end
                if (rel) begin
                    m_ptr[i]   = (m_sel[i] + 1) % 8;
                    m_beats[i] = 0;
                    if (req != 0) m_sel[i] = search(req, m_ptr[i]);
                    else          m_busy[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            logic [7:0]    eg;
            logic          ev;
            logic [DW-1:0] ed;
            eg = m_busy[i] ? (8'd1 << m_sel[i]) : 8'd0;
            ev = m_busy[i] && req[m_sel[i]];
            ed = d_in[m_sel[i]*DW +: DW];
            chk($sformatf("model_grant[%0d]", i), (i == 0) ? g0 : g1, eg);
            chk($sformatf("model_valid[%0d]", i), (i == 0) ? ov0 : ov1, ev);
            if (m_busy[i]) begin
                chk($sformatf("model_sel[%0d]", i), (i == 0) ? os0 : os1, m_sel[i]);
                chk($sformatf("model_data[%0d]", i), (i == 0) ? od0 : od1, ed);
            end
        end
    endtask

    // Entered and left at posedge+1
    task automatic step(input logic [7:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        d_in      = {$urandom, $urandom};
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant0", g0, 8'h00);
        chk("rst_valid0", ov0, 1'b0);
        chk("rst_sel0", os0, 3'd0);
        chk("rst_grant1", g1, 8'h00);
        chk("rst_valid1", ov1, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{8'h05, 1'b1, 8'h01, 8'h01, 1'b1};
        tbl[2] = '{8'h05, 1'b1, 8'h01, 8'h04, 1'b1};
        tbl[3] = '{8'h05, 1'b1, 8'h01, 8'h01, 1'b1};
        tbl[4] = '{8'h05, 1'b1, 8'h01, 8'h04, 1'b1};
        tbl[5] = '{8'h05, 1'b1, 8'h04, 8'h01, 1'b1};
        tbl[6] = '{8'h05, 1'b1, 8'h04, 8'h04, 1'b1};
        tbl[7] = '{8'h05, 1'b1, 8'h04, 8'h01, 1'b1};
        tbl[8] = '{8'h05, 1'b1, 8'h04, 8'h04, 1'b1};
        tbl[9] = '{8'h05, 1'b1, 8'h01, 8'h01, 1'b1};

        #1;
        do_reset();

        // Idle with no requests
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 1'b1);
            chk("idle_grant", g0, 8'h00);
            chk("idle_valid", ov0, 1'b0);
            chk("idle_sel", os0, 3'd0);
        end

        // Two requesters, back-to-back bursts
        for (int k = 0; k < 10; k++) begin
            req = tbl[k].req;
            out_ready = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_grant_mb4", k), g0, tbl[k].g4);
            chk($sformatf("tbl%0d_grant_mb1", k), g1, tbl[k].g1);
            chk($sformatf("tbl%0d_valid", k), ov0, tbl[k].v);
            step(tbl[k].req, tbl[k].rdy);
        end

        // Requester 7 withdraws after one beat, pointer wraps to 0
        do_reset();
        step(8'h80, 1'b1);
        chk("wrap_grant7", g0, 8'h80);
        chk("wrap_sel7", os0, 3'd7);
        step(8'h81, 1'b1);
        step(8'h01, 1'b1);
        chk("wrap_grant0", g0, 8'h01);

        // Stall with out_ready low after two beats
        do_reset();
        step(8'h02, 1'b1);
        step(8'h02, 1'b1);
        step(8'h02, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(8'h02, 1'b0);
            chk("stall_valid", ov0, 1'b1);
            chk("stall_sel", os0, 3'd1);
        end
        step(8'h06, 1'b1);
        chk("stall_hold_grant", g0, 8'h02);
        step(8'h06, 1'b1);
        chk("stall_rotate_grant", g0, 8'h04);

        // All request, MAX_BURST=1 instance rotates every beat
        do_reset();
        step(8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rot%0d_grant_mb1", k), g1, 8'd1 << (k % 8));
            step(8'hFF, 1'b1);
        end

        // Asynchronous reset mid-burst on requester 3
        do_reset();
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        chk("pre_rst_grant", g0, 8'h08);
        do_reset();
        step(8'h18, 1'b1);
        chk("post_rst_grant", g0, 8'h08);
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_burst", g0, 8'h08);
            step(8'h18, 1'b1);
        end
        chk("post_rst_rotate", g0, 8'h10);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            if ($urandom_range(0, 149) == 0) do_reset();
            step(r, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
